latch_array_wr_sched: RTL and testbench

- Write scheduler for a bank of level-sensitive storage latches built from NAND cells.
- Arbitrates round-robin between NREQ requesters and sequences each write as a data-setup / enable-pulse / data-hold phase.
- Latch enables are driven directly from flops: one-hot, glitch-free, non-overlapping.
- Sits between the register-file clients and the latch array.

---
 rtl/latch_array_wr_sched_if.sv | 28 ++
 rtl/latch_array_wr_sched.sv | 138 +++++++++++++
 tb/tb_latch_array_wr_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/latch_array_wr_sched_if.sv
// Write-request and latch-side bus for latch_array_wr_sched.
// master drives requests, slave is the scheduler driving grants and latch controls.
interface latch_array_wr_sched_if #(
    parameter  int NREQ  = 2,
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  done;
    logic                  err;
    logic                  busy;
    logic [DEPTH-1:0]      lat_en;
    logic [WIDTH-1:0]      lat_d;

    modport master (
        output req, req_addr, req_data,
        input  gnt, done, err, busy, lat_en, lat_d
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, done, err, busy, lat_en, lat_d
    );
endinterface

// File: rtl/latch_array_wr_sched.sv
// Round-robin write scheduler driving a NAND-cell latch array (setup/pulse/hold).
// Macro LATCH_WR_BACK2BACK_EN lets HOLD chain straight into the next SETUP.
module latch_array_wr_sched #(
    parameter  int NREQ  = 2,
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input logic                   clk,
    input logic                   rst_n,
    latch_array_wr_sched_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [DEPTH-1:0] lat_en_q, lat_en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             win_vld;
    logic [PW-1:0]    win_idx;
    int unsigned      rr_idx;
    logic             take;
    logic             addr_oor;

    assign addr_oor = 32'(addr_q) >= DEPTH;

    // Round-robin search over req starting at rr_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        rr_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!win_vld && bus.req[rr_idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(rr_idx);
            end
        end
    end

    // Next-state and registered-output computation for the write sequence.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        lat_d_d  = lat_d_q;
        gnt_d    = '0;
        lat_en_d = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        busy_d   = 1'b1;
        take     = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                take   = win_vld;
            end
            SETUP: begin
                state_d = PULSE;
                for (int i = 0; i < DEPTH; i++) begin
                    lat_en_d[i] = 32'(addr_q) == i;
                end
            end
            PULSE: begin
                state_d = HOLD;
                done_d  = 1'b1;
                err_d   = addr_oor;
            end
            HOLD: begin
                state_d = IDLE;
                busy_d  = 1'b0;
`ifdef LATCH_WR_BACK2BACK_EN
                take    = win_vld;
`else
                take    = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (take) begin
            state_d = SETUP;
            busy_d  = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                gnt_d[i] = win_idx == PW'(i);
            end
            addr_d  = bus.req_addr[int'(win_idx)*AW +: AW];
            lat_d_d = bus.req_data[int'(win_idx)*WIDTH +: WIDTH];
            if (int'(win_idx) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx + 1'b1;
            end
        end
    end

    // State and output flops; latch enables come straight from lat_en_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            lat_d_q  <= '0;
            gnt_q    <= '0;
            lat_en_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            lat_d_q  <= lat_d_d;
            gnt_q    <= gnt_d;
            lat_en_q <= lat_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.lat_en = lat_en_q;
    assign bus.lat_d  = lat_d_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_latch_array_wr_sched.sv
// Randomised bench for latch_array_wr_sched against a transaction-level model.
// Directed scenarios first, then 1000 random writes with glitch checks.
`timescale 1ns/1ps
module tb_latch_array_wr_sched;
    localparam int NREQ  = 3;
    localparam int DEPTH = 6;
    localparam int WIDTH = 8;
    localparam int AW    = 3;
`ifdef LATCH_WR_BACK2BACK_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    latch_array_wr_sched_if #(
        .NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)
    ) bus ();

    latch_array_wr_sched #(
        .NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: each granted write schedules its expected outputs into future slots.
    int               slot;
    int               next_eval;
    int               rr;
    int               n_wr;
    int               drop_w;
    logic [WIDTH-1:0] m_latd;
    logic [NREQ-1:0]  e_gnt  [8];
    logic [DEPTH-1:0] e_en   [8];
    logic             e_done [8];
    logic             e_err  [8];
    logic             e_busy [8];
    logic [DEPTH-1:0] prev_en;
    logic [WIDTH-1:0] prev_latd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (slot %0d)",
                     tag, got, exp, slot);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            e_gnt[i]  = '0;
            e_en[i]   = '0;
            e_done[i] = 1'b0;
            e_err[i]  = 1'b0;
            e_busy[i] = 1'b0;
        end
        rr        = 0;
        m_latd    = '0;
        next_eval = slot + 1;
        prev_en   = '0;
        prev_latd = '0;
        drop_w    = -1;
    endtask

    task automatic edge_model();
        int w;
        int a;
        slot++;
        drop_w = -1;
        if (slot == next_eval) begin
            if (bus.req != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && bus.req[(rr + k) % NREQ]) w = (rr + k) % NREQ;
                end
                a = int'(bus.req_addr[w*AW +: AW]);
                e_gnt[slot % 8] = NREQ'(1) << w;
                if (a < DEPTH) e_en[(slot + 1) % 8] = DEPTH'(1) << a;
                e_done[(slot + 2) % 8] = 1'b1;
                e_err[(slot + 2) % 8]  = a >= DEPTH;
                for (int j = 0; j < 3; j++) e_busy[(slot + j) % 8] = 1'b1;
                m_latd    = bus.req_data[w*WIDTH +: WIDTH];
                rr        = (w + 1) % NREQ;
                next_eval = slot + GAP;
                n_wr++;
                drop_w = w;
            end else begin
                next_eval = slot + 1;
            end
        end
    endtask

    task automatic check_slot();
        int s;
        s = slot % 8;
        chk("gnt", bus.gnt, e_gnt[s]);
        chk("lat_en", bus.lat_en, e_en[s]);
        chk("done", bus.done, e_done[s]);
        chk("err", bus.err, e_err[s]);
        chk("busy", bus.busy, e_busy[s]);
        chk("lat_d", bus.lat_d, m_latd);
        chk("en_onehot", $countones(bus.lat_en) <= 1, 1);
        if (bus.lat_d !== prev_latd) begin
            chk("en_vs_d", (bus.lat_en == '0) && (prev_en == '0), 1);
        end
        prev_en   = bus.lat_en;
        prev_latd = bus.lat_d;
        e_gnt[s]  = '0;
        e_en[s]   = '0;
        e_done[s] = 1'b0;
        e_err[s]  = 1'b0;
        e_busy[s] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        edge_model();
        @(negedge clk);
        check_slot();
        if (drop_w >= 0) bus.req[drop_w] = 1'b0;
    endtask

    task automatic set_req(input int i, input int a, input logic [WIDTH-1:0] d);
        bus.req[i]                 = 1'b1;
        bus.req_addr[i*AW +: AW]   = AW'(a);
        bus.req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic drain();
        bus.req = '0;
        repeat (6) step();
    endtask

    initial begin
        logic [NREQ-1:0]  g1;
        logic [NREQ-1:0]  g2;
        logic [DEPTH-1:0] en_any;
        int               t1;
        int               t2;
        int               base;
        logic             errdone;

        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        slot         = 0;
        n_wr         = 0;
        model_reset();

        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_lat_en", bus.lat_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_lat_d", bus.lat_d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // contention from reset: requester 0 first, then 1
        set_req(0, 1, 8'h11);
        set_req(1, 4, 8'h66);
        g1 = '0; g2 = '0; t1 = 0; t2 = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.gnt != '0) begin
                if (g1 == '0) begin
                    g1 = bus.gnt; t1 = slot;
                end else if (g2 == '0) begin
                    g2 = bus.gnt; t2 = slot;
                end
            end
        end
        chk("cont_first", g1, 3'b001);
        chk("cont_second", g2, 3'b010);
        chk("cont_gap", t2 - t1, GAP);

        // single write timeline
        set_req(0, 3, 8'hA5);
        step();
        chk("sw_gnt", bus.gnt, 3'b001);
        chk("sw_latd_1", bus.lat_d, 8'hA5);
        step();
        chk("sw_en", bus.lat_en, 6'b001000);
        step();
        chk("sw_done", bus.done, 1);
        chk("sw_latd_3", bus.lat_d, 8'hA5);
        step();
        chk("sw_busy_low", bus.busy, 0);
        chk("sw_en_off", bus.lat_en, 0);

        // fairness: requester 0 keeps asking, requester 1 asks once
        set_req(0, 2, 8'h20);
        step();
        chk("fair_g0", bus.gnt, 3'b001);
        set_req(0, 2, 8'h21);
        set_req(1, 5, 8'h51);
        g1 = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (g1 == '0 && bus.gnt != '0) g1 = bus.gnt;
            if (!bus.req[0]) bus.req[0] = 1'b1;
        end
        chk("fair_g1", g1, 3'b010);
        drain();

        // out-of-range address
        set_req(2, 7, 8'h77);
        en_any  = '0;
        errdone = 1'b0;
        g1      = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            en_any = en_any | bus.lat_en;
            if (bus.err && bus.done) errdone = 1'b1;
            if (g1 == '0) g1 = bus.gnt;
        end
        chk("oor_gnt", g1, 3'b100);
        chk("oor_en", en_any, 0);
        chk("oor_err_done", errdone, 1);

        // reset asserted during PULSE
        set_req(0, 2, 8'h3C);
        step();
        step();
        chk("rmw_en_pre", bus.lat_en, 6'b000100);
        bus.req = '0;
        rst_n = 1'b0;
        #1;
        chk("rmw_en", bus.lat_en, 0);
        chk("rmw_busy", bus.busy, 0);
        chk("rmw_done", bus.done, 0);
        model_reset();
        set_req(1, 5, 8'h5A);
        #1 rst_n = 1'b1;
        step();
        chk("rmw_first_gnt", bus.gnt, 3'b010);
        drain();

        // random traffic
        base = n_wr;
        for (int c = 0; c < 9000 && n_wr < base + 1000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_req(i, $urandom_range(0, 7), 8'($urandom));
                    end
                end else if ($urandom_range(0, 40) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            step();
        end
        chk("rand_count", n_wr >= base + 1000, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
